// File: rtl/sticky_event_scheduler.sv
// ----------------------------------------------------------------------------
// sticky_event_scheduler
//
// Holds N set-and-hold event flags. A round-robin scheduler offers the pending
// channels one at a time to a single consumer over a valid/ready handshake.
// A flag sets on an event pulse and clears when the consumer accepts the
// offer for that channel. Events that arrive at a flag that is already set
// are counted in a saturating missed-event counter.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         scheduler enable (0 blocks new offers, flags still set)
//   evt        per-channel event set strobes
//   srv_valid  offer valid to consumer
//   srv_id     channel being offered
//   srv_ready  consumer accepts the offer when srv_valid=1
//   pending    current flag state
//   miss_cnt   saturating count of events lost to already-set flags
//   miss_clr   synchronous clear of miss_cnt (wins over increments)
// ----------------------------------------------------------------------------
module sticky_event_scheduler #(
    parameter  int N   = 4,
    parameter  int CW  = 8,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   evt,
    output logic           srv_valid,
    output logic [IDW-1:0] srv_id,
    input  logic           srv_ready,
    output logic [N-1:0]   pending,
    output logic [CW-1:0]  miss_cnt,
    input  logic           miss_clr
);

    localparam int PCW = $clog2(N + 1);
    localparam logic [CW-1:0] MISS_MAX = {CW{1'b1}};

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;

    logic            accept;
    logic [N-1:0]    clr_mask;
    logic [N-1:0]    miss_vec;
    logic [PCW-1:0]  miss_inc;
    logic [CW+PCW-1:0] miss_sum;
    logic            sel_found;
    logic [IDW-1:0]  sel_idx;
    int              idx;

    assign accept = srv_valid & srv_ready;

    // One-hot clear for the channel being accepted this cycle.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        clr_mask = '0;
        if (accept) begin
            clr_mask[srv_id] = 1'b1;
        end
    end

    // A miss is an event hitting a flag that is set and stays set this cycle.
    always_comb begin
        miss_vec = evt & pending & ~clr_mask;
        miss_inc = '0;
        for (int i = 0; i < N; i++) begin
            miss_inc = miss_inc + PCW'(miss_vec[i]);
        end
        miss_sum = {{PCW{1'b0}}, miss_cnt} + {{CW{1'b0}}, miss_inc};
    end

    // Round-robin search: first set bit at or above ptr, wrapping to 0.
    // Uses the registered flags, so same-cycle events are seen next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    // Flags: set wins over a coincident clear.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= evt | (pending & ~clr_mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cnt <= '0;
        end else if (miss_clr) begin
            miss_cnt <= '0;
        end else if (miss_sum > {{PCW{1'b0}}, MISS_MAX}) begin
            miss_cnt <= MISS_MAX;
        end else begin
            miss_cnt <= miss_sum[CW-1:0];
        end
    end

    // Offer FSM. The IDLE state between offers is a mandatory bubble, which
    // limits throughput to one grant every two cycles.
    // NOTE: only control state is reset here; there is no storage array in
    // this block, so every register gets a defined reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            srv_valid <= 1'b0;
            srv_id    <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && sel_found) begin
                        srv_id    <= sel_idx;
                        srv_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    // en is ignored here: an active offer is never withdrawn.
                    if (srv_ready) begin
                        ptr       <= (srv_id == IDW'(N - 1)) ? '0 : srv_id + 1'b1;
                        srv_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    srv_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sticky_event_scheduler.sv
// ----------------------------------------------------------------------------
// tb_sticky_event_scheduler
//
// Directed scenarios plus randomized traffic for sticky_event_scheduler
// (N=4, CW=8). A cycle-level reference model built from the behavioural
// rules (flag set/clear, round-robin pick, saturating miss count) provides
// expected values for the random phase.
// ----------------------------------------------------------------------------
module tb_sticky_event_scheduler;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int IDW = $clog2(N);

    logic           clk;
    logic           rst;
    logic           en;
    logic [N-1:0]   evt;
    logic           srv_valid;
    logic [IDW-1:0] srv_id;
    logic           srv_ready;
    logic [N-1:0]   pending;
    logic [CW-1:0]  miss_cnt;
    logic           miss_clr;

    int n_checks;
    int n_fail;

    // Reference model state
    bit  m_pend [N];
    bit  m_valid;
    int  m_id;
    int  m_ptr;
    int  m_miss;

    sticky_event_scheduler #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .evt       (evt),
        .srv_valid (srv_valid),
        .srv_id    (srv_id),
        .srv_ready (srv_ready),
        .pending   (pending),
        .miss_cnt  (miss_cnt),
        .miss_clr  (miss_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] model_pend_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
        m_miss  = 0;
    endtask

    // Applies the behavioural rules for one rising edge using pre-edge state.
    task automatic model_edge(input logic [N-1:0] e, input logic r,
                              input logic n, input logic c);
        bit acc;
        bit old_pend [N];
        int misses;
        int pick;
        acc    = m_valid && r;
        misses = 0;
        for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
        for (int i = 0; i < N; i++) begin
            bit cleared;
            cleared = acc && (m_id == i);
            if (e[i] && old_pend[i] && !cleared) misses++;
            if (e[i])         m_pend[i] = 1'b1;
            else if (cleared) m_pend[i] = 1'b0;
        end
        if (c) m_miss = 0;
        else   m_miss = (m_miss + misses > 255) ? 255 : m_miss + misses;
        if (!m_valid) begin
            pick = -1;
            if (n) begin
                for (int k = 0; k < N; k++) begin
                    if (pick < 0 && old_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
                end
            end
            if (pick >= 0) begin
                m_id    = pick;
                m_valid = 1'b1;
            end
        end else if (acc) begin
            m_ptr   = (m_id + 1) % N;
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic step(input logic [N-1:0] e, input logic r,
                        input logic n, input logic c);
        evt       = e;
        srv_ready = r;
        en        = n;
        miss_clr  = c;
        @(posedge clk);
        model_edge(e, r, n, c);
        #1;
    endtask

    task automatic do_reset();
        evt = '0; srv_ready = 1'b0; en = 1'b0; miss_clr = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        evt = '0; srv_ready = 1'b0; en = 1'b0; miss_clr = 1'b0;
        rst = 1'b0;
        #2;
        n_checks++;
        if (srv_valid !== 1'b0 || srv_id !== '0 || pending !== '0 || miss_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b id=%0d pending=%b miss=%0d, required 0/0/0000/0",
                     srv_valid, srv_id, pending, miss_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        step(4'b0100, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (pending !== 4'b0100 || srv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_set: pending=%b valid=%b, required 0100/0", pending, srv_valid);
        end
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1 || srv_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_offer: valid=%b id=%0d, required 1/2", srv_valid, srv_id);
        end
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (pending !== 4'b0000 || srv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: pending=%b valid=%b, required 0000/0", pending, srv_valid);
        end
        // ptr is now 3: with channels 0 and 3 pending, channel 3 goes first.
        step(4'b1001, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1 || srv_id !== 2'd3) begin
            n_fail++;
            $display("FAIL single_ptr: valid=%b id=%0d, required 1/3", srv_valid, srv_id);
        end
    endtask

    task automatic test_rotate();
        int ids [$];
        do_reset();
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step(4'b0000, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (srv_valid !== ((c % 2 == 0) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL rotate_gap: cycle %0d valid=%b, required %b",
                         c, srv_valid, (c % 2 == 0));
            end
            if (srv_valid) ids.push_back(int'(srv_id));
        end
        n_checks++;
        if (ids.size() != 4 || ids[0] != 0 || ids[1] != 1 || ids[2] != 2 || ids[3] != 3) begin
            n_fail++;
            $display("FAIL rotate_order: got %0d grants, required ids 0,1,2,3", ids.size());
        end
        n_checks++;
        if (pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL rotate_drain: pending=%b, required 0000", pending);
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step((c == 1 || c == 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (srv_valid !== 1'b1 || srv_id !== 2'd1) begin
                n_fail++;
                $display("FAIL hold_stable: cycle %0d valid=%b id=%0d, required 1/1",
                         c, srv_valid, srv_id);
            end
        end
        n_checks++;
        if (miss_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL hold_miss: miss_cnt=%0d, required 2", miss_cnt);
        end
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (pending[1] !== 1'b0 || srv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_accept: pending=%b valid=%b, required x0x/0", pending, srv_valid);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        step(4'b0010, 1'b0, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b1, 1'b0);    // offer ch1, ch3 becomes pending
        step(4'b0010, 1'b1, 1'b1, 1'b0);    // accept ch1 with a new ch1 event
        n_checks++;
        if (pending !== 4'b1010 || miss_cnt !== 8'd0 || srv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_set_wins: pending=%b miss=%0d valid=%b, required 1010/0/0",
                     pending, miss_cnt, srv_valid);
        end
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1 || srv_id !== 2'd3) begin
            n_fail++;
            $display("FAIL coincide_next: valid=%b id=%0d, required 1/3", srv_valid, srv_id);
        end
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1 || srv_id !== 2'd1) begin
            n_fail++;
            $display("FAIL coincide_reoffer: valid=%b id=%0d, required 1/1", srv_valid, srv_id);
        end
    endtask

    task automatic test_enable();
        do_reset();
        step(4'b1010, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            step(4'b0000, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (srv_valid !== 1'b0 || pending !== 4'b1010) begin
                n_fail++;
                $display("FAIL enable_block: cycle %0d valid=%b pending=%b, required 0/1010",
                         c, srv_valid, pending);
            end
        end
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1 || srv_id !== 2'd1) begin
            n_fail++;
            $display("FAIL enable_resume: valid=%b id=%0d, required 1/1", srv_valid, srv_id);
        end
        // Dropping en does not withdraw the active offer.
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1 || srv_id !== 2'd1) begin
            n_fail++;
            $display("FAIL enable_keep_offer: valid=%b id=%0d, required 1/1", srv_valid, srv_id);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(4'b1111, 1'b0, 1'b0, 1'b0);    // sets all flags, no misses
        for (int c = 0; c < 63; c++) step(4'b1111, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (miss_cnt !== 8'd252) begin
            n_fail++;
            $display("FAIL sat_count: miss_cnt=%0d, required 252", miss_cnt);
        end
        for (int c = 0; c < 12; c++) step(4'b1111, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (miss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold: miss_cnt=%0d after 300 misses, required 255", miss_cnt);
        end
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (miss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_clr_priority: miss_cnt=%0d, required 0", miss_cnt);
        end
        step(4'b0101, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (miss_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL sat_popcount: miss_cnt=%0d, required 2", miss_cnt);
        end
    endtask

    task automatic test_reset_offer();
        do_reset();
        step(4'b0110, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_offer_setup: valid=%b, required 1", srv_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (srv_valid !== 1'b0 || pending !== 4'b0000 || srv_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_offer: valid=%b pending=%b id=%0d, required 0/0000/0",
                     srv_valid, pending, srv_id);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (srv_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_retry: valid=%b, required 0", srv_valid);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] e;
        logic r, n, c;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) e[i] = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 1) == 1);
            n = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 49) == 0);
            step(e, r, n, c);
            n_checks++;
            if (srv_valid !== m_valid || int'(srv_id) != m_id) begin
                n_fail++;
                $display("FAIL rand_offer: cycle %0d valid=%b id=%0d, required %b/%0d",
                         cyc, srv_valid, srv_id, m_valid, m_id);
            end
            n_checks++;
            if (pending !== model_pend_vec()) begin
                n_fail++;
                $display("FAIL rand_pending: cycle %0d pending=%b, required %b",
                         cyc, pending, model_pend_vec());
            end
            n_checks++;
            if (int'(miss_cnt) != m_miss) begin
                n_fail++;
                $display("FAIL rand_miss: cycle %0d miss_cnt=%0d, required %0d",
                         cyc, miss_cnt, m_miss);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; en = 1'b0; evt = '0; srv_ready = 1'b0; miss_clr = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotate();
        test_hold();
        test_coincide();
        test_enable();
        test_saturate();
        test_reset_offer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
